fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch path.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; shows a NOP at pc 0 while empty.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  data_i,
  input  logic          pop_i,
  output fetch_entry_t  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o && !flush_i;
  // a full buffer still takes a push when the head leaves in the same cycle
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = empty_o ? '{pc: '0, instr: NOP_INSTR} : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, results queued for decode.
// state   | meaning
// IDLE    | out of reset, no request yet
// REQ     | may request when buffer + in-flight leaves room
// WAIT    | one request granted, awaiting rvalid
// DISCARD | flushed while in flight; drop the pending response
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_en_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            flush_i,
  input  logic            id_ready_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] tag_q, tag_d;
  logic [CW-1:0]   count;
  logic            full, empty, push, pop, outstanding, space;
  fetch_entry_t    head;

  assign outstanding = (state_q == WAIT) || (state_q == DISCARD);
  assign space       = !full && ((int'(count) + int'(outstanding)) < DEPTH);
  assign pop         = !empty && id_ready_i;

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    imem_req_o = 1'b0;
    push       = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req_o = space && !flush_i;
        if (imem_req_o && imem_gnt_i) begin
          state_d = WAIT;
          tag_d   = pc_i;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          push       = 1'b1;
          state_d    = REQ;
          // the in-flight slot frees this cycle, so a follow-on request may overlap
          imem_req_o = space && !flush_i;
          if (imem_req_o && imem_gnt_i) begin
            state_d = WAIT;
            tag_d   = pc_i;
          end
        end
      end
      DISCARD: if (imem_rvalid_i) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      push    = 1'b0;
      state_d = (outstanding && !imem_rvalid_i) ? DISCARD : REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  ('{pc: tag_q, instr: imem_rdata_i}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign pc_en_o       = imem_req_o && imem_gnt_i;
  assign imem_addr_o   = pc_i;
  assign instr_valid_o = !empty;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

endmodule
